// File: rtl/fifo_pop_ctrl_if.sv
// fifo_pop_ctrl_if: FIFO read side plus valid/ready output handshake of the pop controller.
interface fifo_pop_ctrl_if #(parameter int DATA_W = 4);
    logic              fifo_almost_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd_en;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    modport master (
        input  fifo_almost_empty, fifo_data, out_ready,
        output fifo_rd_en, out_valid, out_data
    );
    modport slave (
        output fifo_almost_empty, fifo_data, out_ready,
        input  fifo_rd_en, out_valid, out_data
    );
endinterface

// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: issues FIFO reads, absorbs the 1-cycle read latency and re-presents
// words through a 2-entry skid buffer on a valid/ready port.
module fifo_pop_ctrl #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    fifo_pop_ctrl_if.master  bus,
    output logic [CNT_W-1:0] delivered_cnt
);
    logic [1:0]        occ, occ_s, occ_nx;
    logic [2:0]        claimed;
    logic              inflight, valid, pop;
    logic [DATA_W-1:0] e0, e1;

    assign pop     = valid && bus.out_ready;
    assign occ_s   = occ - {1'b0, pop};
    assign occ_nx  = occ_s + {1'b0, inflight};
    // slots already owned by buffered or in-flight words once this cycle's pop leaves
    assign claimed = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

    assign bus.fifo_rd_en = rst && enable && !bus.fifo_almost_empty && (claimed < 3'd2);
    assign bus.out_valid  = valid;
    assign bus.out_data   = e0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ           <= '0;
            inflight      <= 1'b0;
            valid         <= 1'b0;
            e0            <= '0;
            e1            <= '0;
            delivered_cnt <= '0;
        end else begin
            occ      <= occ_nx;
            valid    <= occ_nx != 2'd0;
            inflight <= bus.fifo_rd_en;
            e0       <= (inflight && occ_s == 2'd0) ? bus.fifo_data : pop ? e1 : e0;
            e1       <= (inflight && occ_s == 2'd1) ? bus.fifo_data : e1;
            if (pop) delivered_cnt <= delivered_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/fifo_pop_ctrl.md
Name: fifo_pop_ctrl

Overview:
- Downstream consumer stage for the 4-bit FIFO (8 entries, almostEmpty at count <= 2, registered DataOut).
- Drives the FIFO read enable and absorbs the FIFO's 1-cycle read latency.
- Re-presents words on a valid/ready interface through a 2-entry skid buffer, sustaining 1 word/cycle when the sink is always ready.
- Keeps a running count of delivered words for debug.

Parameters:
DATA_W, 4, width of FIFO data and out_data
CNT_W, 8, width of delivered-word counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
enable  input  1  1 = may issue new FIFO reads; 0 = stop issuing, still capture in-flight data
fifo_almost_empty  input  1  FIFO almostEmpty flag
fifo_data  input  DATA_W  FIFO DataOut
fifo_rd_en  output  1  FIFO rd_en
out_valid  output  1  head word valid
out_data  output  DATA_W  head word
out_ready  input  1  sink accepts head word this cycle
delivered_cnt  output  CNT_W  words handed off, wraps

Behaviour:
- Reset (rst=0, async): skid buffer emptied (occ=0), in-flight flag cleared, out_valid=0, out_data=0, delivered_cnt=0, fifo_rd_en=0. Any word in flight at reset is discarded.
- State:
  - occ in 0..2: skid-buffer entries; head=entry0.
  - inflight: registered copy of the previous cycle's fifo_rd_en.
- pop_out = out_valid && out_ready.
- Issue rule (combinational):
  - fifo_rd_en = rst && enable && !fifo_almost_empty && (occ + inflight - pop_out) < 2.
  - fifo_rd_en depends combinationally on out_ready.
- Capture: when inflight=1, fifo_data is sampled at this clock edge into the buffer. Read latency is rd_en cycle N -> word present at fifo_data in N+1 -> in buffer and visible on out_data in N+2.
- Buffer update per edge:
  - If pop_out, shift entry1 to entry0.
  - If capture, write to the lowest free slot after the shift.
  - occ_next = occ + capture - pop_out.
  - Capture never occurs with occ=2 and pop_out=0; the issue rule guarantees this.
- out_valid = (occ != 0), registered.
- While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
- Empty-buffer write plus pop in the same cycle is not possible (pop requires occ>0). With occ=1, pop_out=1 and capture=1, the new word becomes head next cycle.
- delivered_cnt increments by 1 on every pop_out, wrapping from 2^CNT_W-1 to 0.
- enable deassert: no new fifo_rd_en from that cycle. An in-flight word is still captured next edge. Buffered words still drain normally.
- fifo_almost_empty=1: no reads. The FIFO retains 2 or fewer words by design; this block does not force-drain them.
- Throughput: with out_ready=1 constantly and FIFO count > 2, fifo_rd_en stays high every cycle and out_valid is high every cycle after the initial 2-cycle latency.
- Ordering: words emerge in exactly FIFO pop order, with no loss or duplication.

Test Plan:
- Reset/idle: hold rst=0 with random inputs -> fifo_rd_en=0, out_valid=0, out_data=0, delivered_cnt=0. Release rst with fifo_almost_empty=1 -> outputs stay idle.
- Streaming: FIFO preloaded with 6 words 1..6, enable=1, out_ready=1.
  - fifo_rd_en high from cycle 0 until almostEmpty rises (3 pops: 1,2,3 leave count 3 -> after 4th pop count 2).
  - out_data shows 1,2,3,4 on consecutive cycles starting cycle 2.
  - delivered_cnt=4.
- Backpressure: same preload, out_ready=0.
  - Exactly 2 reads issued; occ=2; out_data=1 held stable; fifo_rd_en=0 thereafter.
  - Raise out_ready -> 1,2,3,4 delivered in order with no gaps or duplicates.
- Enable gating: drop enable in the cycle after a read issue -> the in-flight word is still captured and delivered, and no further fifo_rd_en occurs until enable=1.
- Reset mid-flight: assert rst=0 while occ=2 and inflight=1 -> all state cleared immediately (async), delivered_cnt=0. After release, the next delivered word is the next FIFO word.
- Counter wrap: deliver 256 words with CNT_W=8 -> delivered_cnt reads 255, then 0.
